// File: rtl/dpm_pkg.sv
// Shared constants and types for the dual-port-memory FIFO controller.
package dpm_pkg;
  localparam int DATA_W    = 32;
  localparam int ADDR_W    = 4;
  localparam int DEPTH     = 1 << ADDR_W;
  localparam int AF_THRESH = 14;

  // One extra bit so a completely full FIFO (DEPTH) is representable.
  typedef logic [ADDR_W:0]   level_t;
  typedef logic [ADDR_W-1:0] addr_t;
  typedef logic [DATA_W-1:0] data_t;
endpackage

// File: rtl/dpm_fifo_ctrl_if.sv
// Producer/consumer request bus, status flags and memory port drive of the FIFO controller.
interface dpm_fifo_ctrl_if;
  import dpm_pkg::*;

  logic   Push;
  data_t  Push_data;
  logic   Pop;
  logic   Flush;
  logic   Full;
  logic   Empty;
  logic   Almost_full;
  level_t Level;
  logic   Pop_valid;
  logic   Overflow;
  logic   Underflow;
  logic   Mem_wr_en;
  addr_t  Mem_wr_addr;
  data_t  Mem_data_in;
  logic   Mem_rd_en;
  addr_t  Mem_rd_addr;

  modport master (
    output Push, Push_data, Pop, Flush,
    input  Full, Empty, Almost_full, Level, Pop_valid, Overflow, Underflow,
    input  Mem_wr_en, Mem_wr_addr, Mem_data_in, Mem_rd_en, Mem_rd_addr
  );

  modport slave (
    input  Push, Push_data, Pop, Flush,
    output Full, Empty, Almost_full, Level, Pop_valid, Overflow, Underflow,
    output Mem_wr_en, Mem_wr_addr, Mem_data_in, Mem_rd_en, Mem_rd_addr
  );
endinterface

// File: rtl/dpm_ptr.sv
// Wrapping ADDR_W-bit address pointer; clr has priority over inc.
module dpm_ptr
  import dpm_pkg::*;
(
  input  logic  Clk,
  input  logic  Rst,
  input  logic  inc,
  input  logic  clr,
  output addr_t ptr
);
  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      ptr <= '0;
    end else if (clr) begin
      ptr <= '0;
    end else if (inc) begin
      ptr <= ptr + addr_t'(1);
    end
  end
endmodule

// File: rtl/dpm_fifo_ctrl.sv
// Sequencer making a 16x32 dual-port memory behave as a synchronous FIFO.
// Memory port outputs are registered; the memory samples them on the following falling edge.
module dpm_fifo_ctrl
  import dpm_pkg::*;
(
  input  logic           Clk,
  input  logic           Rst,
  dpm_fifo_ctrl_if.slave bus
);
  localparam level_t LVL_FULL = level_t'(DEPTH);
  localparam level_t LVL_AF   = level_t'(AF_THRESH);

  level_t level_q;
  addr_t  wr_ptr;
  addr_t  rd_ptr;
  logic   full;
  logic   empty;
  logic   push_ok;
  logic   pop_ok;
  logic   ovf_q;
  logic   udf_q;
  logic   wr_en_q;
  logic   rd_en_q;
  addr_t  wr_addr_q;
  addr_t  rd_addr_q;
  data_t  data_q;

  assign full    = (level_q == LVL_FULL);
  assign empty   = (level_q == '0);
  assign push_ok = bus.Push & ~full & ~bus.Flush;
  assign pop_ok  = bus.Pop & ~empty & ~bus.Flush;

  dpm_ptr u_wr_ptr (
    .Clk (Clk),
    .Rst (Rst),
    .inc (push_ok),
    .clr (bus.Flush),
    .ptr (wr_ptr)
  );

  dpm_ptr u_rd_ptr (
    .Clk (Clk),
    .Rst (Rst),
    .inc (pop_ok),
    .clr (bus.Flush),
    .ptr (rd_ptr)
  );

  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      level_q <= '0;
      ovf_q   <= 1'b0;
      udf_q   <= 1'b0;
    end else if (bus.Flush) begin
      level_q <= '0;
      ovf_q   <= 1'b0;
      udf_q   <= 1'b0;
    end else begin
      if (push_ok && !pop_ok) begin
        level_q <= level_q + level_t'(1);
      end else if (pop_ok && !push_ok) begin
        level_q <= level_q - level_t'(1);
      end
      if (bus.Push && full) ovf_q <= 1'b1;
      if (bus.Pop && empty) udf_q <= 1'b1;
    end
  end

  // Addresses and write data hold their last values between accepted requests.
  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      wr_en_q   <= 1'b0;
      rd_en_q   <= 1'b0;
      wr_addr_q <= '0;
      rd_addr_q <= '0;
      data_q    <= '0;
    end else begin
      wr_en_q <= push_ok;
      rd_en_q <= pop_ok;
      if (push_ok) begin
        wr_addr_q <= wr_ptr;
        data_q    <= bus.Push_data;
      end
      if (pop_ok) begin
        rd_addr_q <= rd_ptr;
      end
    end
  end

  assign bus.Full        = full;
  assign bus.Empty       = empty;
  assign bus.Almost_full = (level_q >= LVL_AF);
  assign bus.Level       = level_q;
  assign bus.Overflow    = ovf_q;
  assign bus.Underflow   = udf_q;
  assign bus.Mem_wr_en   = wr_en_q;
  assign bus.Mem_wr_addr = wr_addr_q;
  assign bus.Mem_data_in = data_q;
  assign bus.Mem_rd_en   = rd_en_q;
  assign bus.Mem_rd_addr = rd_addr_q;
  // The popped word is on the memory output for exactly the cycle the read is issued.
  assign bus.Pop_valid   = rd_en_q;
endmodule
